// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types for the right shift sequencer
package shift_pkg;

    typedef enum logic {
        SHIFT_ARITH = 1'b0,
        SHIFT_LOGIC = 1'b1
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } rss_state_t;

endpackage

// File: rtl/shift_down_counter.sv
// rtl/shift_down_counter.sv - loadable down counter with one/zero flags
module shift_down_counter #(
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [SHW-1:0] load_val,
    input  logic           dec,
    output logic           is_one,
    output logic           is_zero
);

    logic [SHW-1:0] cnt;

    // Saturates at zero so a stray decrement can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one  = (cnt == SHW'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/right_shift_sequencer.sv
// rtl/right_shift_sequencer.sv - one-bit-per-clock right shifter with start/busy/done
// Optional sticky output (OR of shifted-out bits) enabled by defining RSS_STICKY_EN.
module right_shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
`ifdef RSS_STICKY_EN
    ,
    output logic             sticky
`endif
);

    rss_state_t       state_q, state_d;
    shift_mode_t      mode_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_clamped;
    logic             load, step;
    logic             cnt_is_one, cnt_is_zero;

    assign shamt_clamped = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
    assign load          = (state_q == IDLE) && start;
    assign step          = (state_q == SHIFT);

    shift_down_counter #(.SHW(SHW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (shamt_clamped),
        .dec      (step),
        .is_one   (cnt_is_one),
        .is_zero  (cnt_is_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (shamt_clamped == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt_is_one || cnt_is_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured at load so later input changes cannot disturb the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            mode_q <= SHIFT_ARITH;
        end else if (load) begin
            data_q <= din;
            mode_q <= shift_mode_t'(mode);
        end else if (step) begin
            data_q <= (mode_q == SHIFT_LOGIC) ? {1'b0, data_q[WIDTH-1:1]}
                                              : {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        end
    end

`ifdef RSS_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (load) begin
            sticky <= 1'b0;
        end else if (step) begin
            sticky <= sticky | data_q[0];
        end
    end
`endif

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign dout = data_q;

endmodule

// File: tb/tb_right_shift_sequencer.sv
// tb/tb_right_shift_sequencer.sv - randomized and directed bench for right_shift_sequencer
// Sticky checks are compiled in when RSS_STICKY_EN is defined.
module tb_right_shift_sequencer;

    localparam int W   = 16;
    localparam int SHW = 5;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   din   = '0;
    logic [SHW-1:0] shamt = '0;
    logic           mode  = 1'b0;
    logic           busy, done;
    logic [W-1:0]   dout;
`ifdef RSS_STICKY_EN
    logic           sticky;
`endif

    right_shift_sequencer #(.WIDTH(W), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .shamt (shamt),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
`ifdef RSS_STICKY_EN
        ,
        .sticky(sticky)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int n, input logic m);
        logic signed [W-1:0] s;
        s = d;
        if (n >= W) return (m || !d[W-1]) ? '0 : '1;
        if (m) return d >> n;
        return s >>> n;
    endfunction

    function automatic logic ref_sticky(input logic [W-1:0] d, input int n);
        logic [31:0] mask;
        if (n >= W) return (d != '0);
        mask = (32'd1 << n) - 32'd1;
        return ((32'(d) & mask) != 32'd0);
    endfunction

    // Reference model: timeline of the accepted operation in clock-edge numbers.
    int          cyc     = 0;
    int          t0      = 0;
    int          n_op    = 0;
    int          free_at = 0;
    bit          active  = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic        exp_st  = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            active  = 1'b0;
            free_at = 0;
        end else if (start && cyc >= free_at) begin
            t0      = cyc;
            n_op    = (int'(shamt) > W) ? W : int'(shamt);
            exp_res = ref_shift(din, n_op, mode);
            exp_st  = ref_sticky(din, n_op);
            active  = 1'b1;
            free_at = cyc + n_op + 2;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_dout", 32'(dout), 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(active && cyc >= t0 && cyc < t0 + n_op));
            chk("done", 32'(done), 32'(active && cyc == t0 + n_op));
            if (!active) begin
                chk("idle_dout", 32'(dout), 32'd0);
`ifdef RSS_STICKY_EN
                chk("idle_sticky", 32'(sticky), 32'd0);
`endif
            end else if (cyc >= t0 + n_op) begin
                chk("dout", 32'(dout), 32'(exp_res));
`ifdef RSS_STICKY_EN
                chk("sticky", 32'(sticky), 32'(exp_st));
`endif
            end
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] d, input logic [SHW-1:0] s,
                          input logic m, input logic [W-1:0] exp_d, input int exp_lat,
                          input int exp_busy);
        int lat;
        int nbusy;
        start = 1'b1;
        din   = d;
        shamt = s;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        chk({name, "_dout"}, 32'(dout), 32'(exp_d));
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        int lat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("arith",   16'h8000, 5'd3,  1'b0, 16'hF000, 3,  3);
        run_op("logical", 16'h8000, 5'd3,  1'b1, 16'h1000, 3,  3);
        run_op("zero",    16'h1234, 5'd0,  1'b0, 16'h1234, 0,  0);
        run_op("clamp_a", 16'h8001, 5'd20, 1'b0, 16'hFFFF, 16, 16);
        run_op("clamp_l", 16'h8001, 5'd20, 1'b1, 16'h0000, 16, 16);
        run_op("sticky1", 16'h0005, 5'd2,  1'b1, 16'h0001, 2,  2);
`ifdef RSS_STICKY_EN
        chk("sticky1_val", 32'(sticky), 32'd1);
`endif
        run_op("sticky0", 16'h0004, 5'd2,  1'b1, 16'h0001, 2,  2);
`ifdef RSS_STICKY_EN
        chk("sticky0_val", 32'(sticky), 32'd0);
`endif

        // Start pulsed mid-operation with different operands must be ignored.
        start = 1'b1; din = 16'h8000; shamt = 5'd8; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; din = 16'hFFFF; shamt = 5'd1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_timeout", 32'(lat < 40), 32'd1);
        chk("ignore_dout", 32'(dout), 32'h0000_FF80);
        @(negedge clk);

        // Reset mid-shift aborts with no done.
        start = 1'b1; din = 16'hA5A5; shamt = 5'd10; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        repeat (2500) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            din   = W'($urandom);
            shamt = SHW'($urandom_range(0, 20));
            mode  = 1'($urandom % 2);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
